pipe_stage_hs: RTL and testbench
================================

PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter NEG_EDGE, default 0: 0 means capture on the rising edge of clk, 1 on the falling edge.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream has data.
REQ-007 SHALL have port in_ready, output, 1 bit: stage accepts data this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts data.
REQ-011 SHALL have port out_data, output, WIDTH bits: head payload.
REQ-012 SHALL have port occupancy, output, 2 bits: number of held entries, 0..2.

Function
REQ-013 SHALL define an input transfer as in_valid && in_ready at the active edge, and an output transfer as out_valid && out_ready at the active edge.
REQ-014 SHALL have a latency of exactly 1 active edge from an input transfer into an empty stage to out_valid=1, with out_data equal to the accepted in_data.
REQ-015 SHALL hold out_data and out_valid stable while out_valid=1 && out_ready=0.
REQ-016 SHALL preserve entry order; no entry is duplicated or dropped except by flush or rst.
REQ-017 SHALL, when an input transfer and an output transfer occur at the same edge, replace the head with the new entry (or the skid entry, per REQ-024) with no bubble.
REQ-018 SHALL give flush priority over all transfers: at the next active edge occupancy=0 and out_valid=0; any input transfer in the flush cycle is discarded; out_data keeps its last value.
REQ-019 SHALL never accept an entry while occupancy equals the configured maximum (1 without skid, 2 with skid).
REQ-020 SHALL ignore in_valid and out_ready while rst=1.

Reset
REQ-021 SHALL, while rst=1, force out_valid=0, out_data=0, occupancy=0 and in_ready=1, with any skid entry cleared.
REQ-022 SHALL accept a transfer on the first active edge after rst deasserts, and SHALL drop any in-flight entries when reset is asserted mid-operation.

Configuration
REQ-023 SHALL, with macro PIPE_STAGE_HS_SKID_EN undefined, hold one entry and drive in_ready = !out_valid || out_ready (a combinational path from out_ready); occupancy is then 0..1.
REQ-024 SHALL, with PIPE_STAGE_HS_SKID_EN defined, add a second (skid) entry and drive in_ready from a flop equal to "skid empty" (no combinational path from out_ready), at full throughput.
  - Skid mode, head full and stalled: an input transfer goes into the skid entry.
  - Skid mode, output transfer: the skid entry moves into the head.

Structure
REQ-025 SHALL place the occupancy typedef (2-bit) and the default WIDTH constant in shared package pipe_pkg.
REQ-026 SHALL implement each storage entry as sub-module pipe_data_reg (WIDTH, NEG_EDGE, enable, async reset to 0), instantiated once, or twice with skid.
REQ-027 SHALL select the capture edge via generate on NEG_EDGE only; no clock inversion outside pipe_data_reg and the valid flops.

Verification
REQ-028 SHALL cover: rst pulse mid-stream with occupancy=2 -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0.
REQ-029 SHALL cover: streaming 0x1..0x10 with out_ready=1 -> 16 outputs in order, one per cycle after 1-cycle latency.
REQ-030 SHALL cover: skid build, push 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA stable; out_ready=1 -> 0xA then 0xB.
REQ-031 SHALL cover: no-skid build, out_valid=1 with out_ready toggling -> in_ready mirrors out_ready each cycle.
REQ-032 SHALL cover: flush together with in_valid=1 and data 0x55 -> next edge out_valid=0, 0x55 never appears.
REQ-033 SHALL cover: NEG_EDGE=1 -> captures occur only on falling clk edges, and all other checks above pass.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshake pipeline stage.
package pipe_pkg;
  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/pipe_data_reg.sv
// One payload storage entry: enabled register with async active-high clear,
// capturing on the rising or falling clock edge selected by NEG_EDGE.
module pipe_data_reg #(
  parameter int WIDTH    = 32,
  parameter bit NEG_EDGE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
      end
    end else begin : g_pos
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage. Define PIPE_STAGE_HS_SKID_EN to add a skid entry
// so in_ready comes from a flop instead of combinationally from out_ready.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit NEG_EDGE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output occ_t             occupancy
);

  logic             head_valid, head_valid_n;
  logic             skid_valid, skid_valid_n;
  logic             head_en;
  logic [WIDTH-1:0] head_d;
  logic             in_xfer, out_xfer;

`ifdef PIPE_STAGE_HS_SKID_EN
  logic             skid_en;
  logic [WIDTH-1:0] skid_q;

  // The skid entry can only be full when upstream is blocked, so in_ready is
  // simply the inverse of a registered bit.
  assign in_ready = !skid_valid;
`else
  assign in_ready = !head_valid || out_ready;
`endif

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = head_valid && out_ready;
  assign out_valid = head_valid;
  assign occupancy = occ_t'({1'b0, head_valid}) + occ_t'({1'b0, skid_valid});

  always_comb begin
    head_en      = 1'b0;
    head_d       = in_data;
    head_valid_n = head_valid;
    skid_valid_n = skid_valid;
`ifdef PIPE_STAGE_HS_SKID_EN
    skid_en      = 1'b0;
`endif
    if (flush) begin
      head_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
`ifdef PIPE_STAGE_HS_SKID_EN
      // A stalled full head diverts the new entry into the skid slot; a
      // draining head refills from the skid slot before taking new input.
      head_en = (in_xfer && (!head_valid || out_xfer)) || (out_xfer && skid_valid);
      skid_en = in_xfer && head_valid && !out_xfer;
      if (skid_valid) head_d = skid_q;
      if (skid_en)       skid_valid_n = 1'b1;
      else if (out_xfer) skid_valid_n = 1'b0;
`else
      head_en = in_xfer;
`endif
      if (head_en)       head_valid_n = 1'b1;
      else if (out_xfer) head_valid_n = 1'b0;
    end
  end

  generate
    if (NEG_EDGE) begin : g_valid_neg
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else begin
          head_valid <= head_valid_n;
          skid_valid <= skid_valid_n;
        end
      end
    end else begin : g_valid_pos
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else begin
          head_valid <= head_valid_n;
          skid_valid <= skid_valid_n;
        end
      end
    end
  endgenerate

  pipe_data_reg #(.WIDTH(WIDTH), .NEG_EDGE(NEG_EDGE)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (head_en),
    .d   (head_d),
    .q   (out_data)
  );

`ifdef PIPE_STAGE_HS_SKID_EN
  pipe_data_reg #(.WIDTH(WIDTH), .NEG_EDGE(NEG_EDGE)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs: vector table plus scoreboard queue.
// Honours PIPE_STAGE_HS_SKID_EN and the NEG_EDGE bench parameter.
module tb_pipe_stage_hs #(
  parameter bit NEG_EDGE = 1'b0
);
  import pipe_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  occ_t         occupancy;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         iv;
    logic         ordy;
    logic         fl;
    logic [W-1:0] d;
    int           occ_ns;
    int           occ_sk;
  } vec_t;

  vec_t tbl[11];

  pipe_stage_hs #(.WIDTH(W), .NEG_EDGE(NEG_EDGE)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic active_edge();
    if (NEG_EDGE) @(negedge clk);
    else          @(posedge clk);
  endtask

  task automatic inactive_edge();
    if (NEG_EDGE) @(posedge clk);
    else          @(negedge clk);
  endtask

  // Check DUT against the model just before the active edge, then advance the model.
  task automatic step();
    int   occ_m;
    logic exp_ir;
    logic pop;
    logic push;
    #1;
    occ_m = exp_q.size();
`ifdef PIPE_STAGE_HS_SKID_EN
    exp_ir = (occ_m < 2);
`else
    exp_ir = (occ_m == 0) || out_ready;
`endif
    check_output("out_valid", {63'd0, out_valid}, {63'd0, occ_m != 0});
    check_output("occupancy", {62'd0, occupancy}, 64'(occ_m));
    check_output("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
    if (occ_m != 0) check_output("head_data", 64'(out_data), 64'(exp_q[0]));
    pop  = (occ_m != 0) && out_ready;
    push = in_valid && exp_ir;
    active_edge();
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (push) exp_q.push_back(in_data);
    end
    #1;
  endtask

  task automatic apply_stimulus(input logic iv, input logic ordy, input logic fl, input logic [W-1:0] d);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = d;
    step();
  endtask

  initial begin
    int out_base;
    int exp_occ;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h11, 1, 1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1, 1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h00, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h22, 1, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h33, 1, 1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h55, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h00, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h44, 1, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h66, 1, 2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 0, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 0, 0};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hDEAD;
    #12;
    check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_occupancy", {62'd0, occupancy}, 64'd0);
    check_output("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("rst_out_data", 64'(out_data), 64'd0);
    step();
    rst = 1'b0;

    // Table vectors; the first one lands on the first edge after reset release.
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].d);
`ifdef PIPE_STAGE_HS_SKID_EN
      exp_occ = tbl[i].occ_sk;
`else
      exp_occ = tbl[i].occ_ns;
`endif
      check_output($sformatf("tbl_occ[%0d]", i), {62'd0, occupancy}, 64'(exp_occ));
    end

    // Streaming 1..16 at full rate; nothing may be captured on the inactive edge.
    out_base = n_out;
    for (int i = 1; i <= 16; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      flush     = 1'b0;
      in_data   = W'(i);
      if (i == 1) begin
        inactive_edge();
        #1;
        check_output("no_inactive_capture", {63'd0, out_valid}, 64'd0);
      end
      step();
      if (i == 1) begin
        check_output("latency_valid", {63'd0, out_valid}, 64'd1);
        check_output("latency_data", 64'(out_data), 64'h1);
      end
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("stream_count", 64'(n_out - out_base), 64'd16);
    check_output("stream_drained", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_HS_SKID_EN
    // Two entries held under stall, then drained in order.
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'hA);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'hB);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("skid_occ", {62'd0, occupancy}, 64'd2);
    check_output("skid_in_ready", {63'd0, in_ready}, 64'd0);
    check_output("skid_head_a", 64'(out_data), 64'hA);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("skid_head_b", 64'(out_data), 64'hB);
    check_output("skid_occ_1", {62'd0, occupancy}, 64'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("skid_empty", {62'd0, occupancy}, 64'd0);
`endif

    // Held head with out_ready toggling while upstream keeps offering data.
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h31);
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'b1;
      in_data   = 32'h40 + W'(i);
      out_ready = i[0];
`ifndef PIPE_STAGE_HS_SKID_EN
      #1;
      check_output($sformatf("in_ready_mirror[%0d]", i), {63'd0, in_ready}, {63'd0, i[0]});
`endif
      step();
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);

    // Flush while offering 0x55: stage empties and 0x55 never surfaces.
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h21);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h55);
    check_output("flush_valid", {63'd0, out_valid}, 64'd0);
    check_output("flush_occ", {62'd0, occupancy}, 64'd0);
    check_output("flush_data_kept", 64'(out_data), 64'h21);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("flush_no_55", 64'(out_data), 64'h21);

    // Reset asserted mid-stream with the stage full.
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'hC1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'hC2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_output("midrst_valid", {63'd0, out_valid}, 64'd0);
    check_output("midrst_occ", {62'd0, occupancy}, 64'd0);
    check_output("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("midrst_data", 64'(out_data), 64'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h77);
    check_output("rst_ignores_input", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h88);
    check_output("post_rst_accept", 64'(out_data), 64'h88);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
